// File: rtl/line_follow_ctrl.sv
// line_follow_ctrl: debounced N-sensor line follower driving the 3-bit turn code,
// with track/node/lost-line steering FSM and node counting.
module line_follow_ctrl #(
  parameter int NUM_SENSORS  = 3,
  parameter int SAMPLE_DIV   = 50000,
  parameter int FILTER_LEN   = 4,
  parameter int NODE_HOLD    = 100,
  parameter int LOST_TIMEOUT = 200
) (
  input  logic                   clk_50,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] sensor,
  output logic [2:0]             turn,
  output logic                   pivot_dir,
  output logic                   node_pulse,
  output logic [7:0]             node_count,
  output logic                   lost
);
  localparam int N  = NUM_SENSORS;
  localparam int C  = (N - 1) / 2;
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int SW = $clog2(FILTER_LEN + 1);
  localparam int HW = $clog2(NODE_HOLD + 1);
  localparam int LW = $clog2(LOST_TIMEOUT + 1);
  localparam logic [N-1:0] ONLY_L = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ONLY_R = {{(N-1){1'b0}}, 1'b1};
  typedef enum logic [2:0] {S_IDLE, S_TRACK, S_NODE, S_NODE_EXIT, S_LOST, S_FAULT} state_t;
  typedef enum logic [2:0] {K_NONE, K_NODE, K_EXL, K_EXR, K_FWD, K_LEFT, K_RIGHT} cls_t;
  state_t        state;
  cls_t          cls;
  logic [DW-1:0] div_cnt;
  logic [SW-1:0] stable, stable_nx;
  logic [N-1:0]  cand, filt, filt_nx;
  logic [HW-1:0] hold_cnt;
  logic [LW-1:0] loss_cnt;
  logic          tick, last_side, side_nx;
  logic [2:0]    trk_turn;
  // Decisions on a tick use the pattern accepted on that same tick.
  always_comb begin
    tick      = div_cnt == DW'(SAMPLE_DIV - 1);
    stable_nx = sensor != cand ? SW'(1) : stable == SW'(FILTER_LEN) ? stable : stable + 1'b1;
    filt_nx   = tick && stable_nx == SW'(FILTER_LEN) ? sensor : filt;
    cls       = &filt_nx ? K_NODE :
                ~|filt_nx ? K_NONE :
                filt_nx == ONLY_L ? K_EXL :
                filt_nx == ONLY_R ? K_EXR :
                filt_nx[C] || (|filt_nx[N-1:C+1] && |filt_nx[C-1:0]) ? K_FWD :
                |filt_nx[N-1:C+1] ? K_LEFT : K_RIGHT;
    side_nx   = cls == K_LEFT || cls == K_EXL ? 1'b1 :
                cls == K_RIGHT || cls == K_EXR ? 1'b0 : last_side;
    trk_turn  = cls == K_LEFT ? 3'b010 :
                cls == K_RIGHT ? 3'b011 :
                cls == K_EXL || cls == K_EXR ? 3'b100 : 3'b001;
  end
  always_ff @(posedge clk_50) begin
    if (reset) begin
      div_cnt   <= '0;
      cand      <= '0;
      stable    <= '0;
      filt      <= '0;
      last_side <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        cand      <= sensor;
        stable    <= stable_nx;
        filt      <= filt_nx;
        last_side <= side_nx;
      end
    end
  end
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state      <= S_IDLE;
      turn       <= 3'b000;
      pivot_dir  <= 1'b0;
      node_pulse <= 1'b0;
      node_count <= 8'd0;
      lost       <= 1'b0;
      hold_cnt   <= '0;
      loss_cnt   <= '0;
    end else begin
      node_pulse <= 1'b0;
      if (!enable) begin
        state <= S_IDLE;
        turn  <= 3'b000;
        lost  <= 1'b0;
      end else if (tick) begin
        case (state)
          S_IDLE: state <= S_TRACK;
          S_TRACK:
            if (cls == K_NODE) begin
              state      <= S_NODE;
              turn       <= 3'b000;
              node_pulse <= 1'b1;
              node_count <= node_count == 8'd255 ? node_count : node_count + 1'b1;
              hold_cnt   <= '0;
            end else if (cls == K_NONE) begin
              state     <= S_LOST;
              turn      <= 3'b100;
              pivot_dir <= last_side;
              lost      <= 1'b1;
              loss_cnt  <= '0;
            end else begin
              turn      <= trk_turn;
              pivot_dir <= side_nx;
            end
          S_NODE:
            if (hold_cnt == HW'(NODE_HOLD - 1)) begin
              state <= S_NODE_EXIT;
              turn  <= 3'b001;
            end else hold_cnt <= hold_cnt + 1'b1;
          S_NODE_EXIT: if (cls != K_NODE) state <= S_TRACK;
          S_LOST:
            if (cls != K_NONE) begin
              state     <= S_TRACK;
              turn      <= trk_turn;
              pivot_dir <= side_nx;
              lost      <= 1'b0;
            end else if (loss_cnt == LW'(LOST_TIMEOUT - 1)) begin
              state <= S_FAULT;
              turn  <= 3'b101;
            end else loss_cnt <= loss_cnt + 1'b1;
          S_FAULT: state <= S_FAULT;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/line_follow_ctrl.md
Name: line_follow_ctrl

Overview:
- Parametrised line-follower steering controller; replaces the fixed 3-sensor per-clock decoder.
- Samples an N-wide IR sensor bank on a divided tick and debounces each pattern.
- Classifies the line position and runs a tracking/node/lost-line state machine.
- Drives the existing 3-bit turn code to the motor driver and reports node count and line-loss status to the path planner.

Parameters:
NUM_SENSORS, 3, number of line sensors; must be odd and >= 3; sensor[NUM_SENSORS-1] is leftmost, centre index C = (NUM_SENSORS-1)/2
SAMPLE_DIV, 50000, clk_50 cycles per sample tick (1 ms at 50 MHz); must be >= 2
FILTER_LEN, 4, consecutive identical ticks required to accept a new sensor pattern; must be >= 1
NODE_HOLD, 100, ticks spent stopped at a node
LOST_TIMEOUT, 200, ticks in LOST before declaring FAULT

Ports:
clk_50  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
enable  in  1  run control; 0 forces IDLE
sensor  in  NUM_SENSORS  raw sensor bits, 1 = over line; already synchronised upstream
turn  out  3  000 stop, 001 forward, 010 left, 011 right, 100 pivot, 101 path_out
pivot_dir  out  1  valid when turn=100; 1 = pivot left, 0 = pivot right
node_pulse  out  1  one-cycle pulse on NODE entry
node_count  out  8  nodes passed since reset; saturates at 255
lost  out  1  high in LOST and FAULT

Behaviour:
- Reset values: turn=000, pivot_dir=0, node_pulse=0, node_count=0, lost=0, filt=0, state IDLE, all counters 0.
- Tick: free-running counter 0..SAMPLE_DIV-1; tick is asserted for one cycle when the counter reaches SAMPLE_DIV-1.
- Filter: on each tick, compare sensor with cand.
  - If different: load cand and set stable=1.
  - If equal: increment stable, saturating.
  - When stable reaches FILTER_LEN, load filt := cand on that tick.
  - With FILTER_LEN=1, filt follows sensor every tick.
- Classification of filt (combinational). L = any bit above C; R = any bit below C; M = bit C.
  - All ones -> NODE_PAT.
  - All zero -> NONE.
  - Only sensor[N-1] set, or only sensor[0] set -> EXTREME, with side as indicated.
  - M set, or L and R both set -> FWD.
  - L set, R clear -> LEFT.
  - R set, L clear -> RIGHT.
  - Otherwise -> hold previous turn.
- State transitions are evaluated only on ticks, using filt as updated on that same tick. Outputs are registered, so turn changes exactly 1 clk_50 cycle after the tick that changed filt.
- last_side register: set to 1 on LEFT or left EXTREME, set to 0 on RIGHT or right EXTREME, otherwise held.
- IDLE: turn=000, lost=0. Go to TRACK when enable=1.
- TRACK:
  - turn follows classification: FWD -> 001, LEFT -> 010, RIGHT -> 011, EXTREME -> 100 with pivot_dir = side.
  - NODE_PAT -> NODE: node_pulse for 1 cycle, node_count+1 (saturating), hold counter cleared.
  - NONE -> LOST: loss counter cleared.
- NODE: turn=000 for NODE_HOLD ticks, then NODE_EXIT.
- NODE_EXIT: turn=001. Stay until filt is not all ones, then go to TRACK.
- LOST:
  - turn=100, pivot_dir=last_side, lost=1.
  - Any non-zero filt -> TRACK, lost=0 on the next cycle.
  - Loss counter reaching LOST_TIMEOUT -> FAULT.
- FAULT: turn=101, lost=1. Exit only via enable=0 (to IDLE) or reset.
- enable=0 in any state: IDLE on the next clk_50 edge, not gated by tick. Counters, node_count and filt are retained.
- reset mid-operation: all registers return to reset values on the same edge; reset has priority over enable.
- Simultaneous events: a tick that also sees enable falling goes to IDLE. A node seen on the same tick as timeout expiry is not possible because states are exclusive.

Test Plan:
Bench parameters: NUM_SENSORS=5, SAMPLE_DIV=4, FILTER_LEN=2, NODE_HOLD=3, LOST_TIMEOUT=5.
1. Reset then enable=1, sensor=00100 held -> after the 2nd tick filt=00100 and turn=001 one cycle later; node_count=0, lost=0.
2. From case 1, sensor=11000 held -> turn=010. Then sensor=00001 -> turn=100, pivot_dir=0. A 1-tick 10000 glitch between these leaves turn unchanged.
3. sensor=11111 held -> single-cycle node_pulse, node_count=1, turn=000 for 3 ticks then 001. Then sensor=00100 -> TRACK, turn=001.
4. After a LEFT (01000), sensor=00000 -> turn=100, pivot_dir=1, lost=1. Restore 00100 within 4 ticks -> turn=001, lost=0.
5. sensor=00000 held past 5 ticks -> turn=101, lost=1. Restoring 00100 keeps turn=101. enable=0 -> turn=000 next edge, lost=0.
6. 256 node passes -> node_count stays 255. Assert reset mid-NODE -> all outputs 000/0 on the following edge.
